// File: rtl/dkstr_pkg.sv
// Shared types and constants for the grid solve sequencer.
package dkstr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [2:0] PHASE_LAST     = 3'd7;
  localparam logic [3:0] WEIGHT_BLOCKED = 4'hF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/grid_seq_loader.sv
// Raster beat counter that turns accepted weight beats into registered load strobes.
module grid_seq_loader
  import dkstr_pkg::*;
#(
  parameter int CELLS = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          accept,
  input  logic [3:0]    w_data,
  output logic [AW-1:0] idx,
  output logic          last,
  output logic          ld,
  output logic [AW-1:0] ld_addr,
  output logic [3:0]    ld_weight
);

  logic [AW-1:0] idx_q, idx_d;
  logic          ld_q, ld_d;
  logic [AW-1:0] ld_addr_q, ld_addr_d;
  logic [3:0]    ld_weight_q, ld_weight_d;

  assign idx  = idx_q;
  assign last = (idx_q == AW'(CELLS - 1));

  always_comb begin
    idx_d       = idx_q;
    ld_d        = accept;
    ld_addr_d   = accept ? idx_q : '0;
    ld_weight_d = accept ? w_data : 4'h0;
    if (clr) begin
      idx_d = '0;
    end else if (accept) begin
      idx_d = last ? '0 : idx_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      ld_q        <= 1'b0;
      ld_addr_q   <= '0;
      ld_weight_q <= 4'h0;
    end else begin
      idx_q       <= idx_d;
      ld_q        <= ld_d;
      ld_addr_q   <= ld_addr_d;
      ld_weight_q <= ld_weight_d;
    end
  end

  assign ld        = ld_q;
  assign ld_addr   = ld_addr_q;
  assign ld_weight = ld_weight_q;

endmodule

// File: rtl/grid_seq.sv
// Sequencer for a grid of node units: loads weights, seeds the source cell,
// then counts 8-phase sweeps until the grid goes quiet or the sweep limit hits.
module grid_seq
  import dkstr_pkg::*;
#(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int MAX_SWEEPS   = 255,
  parameter int QUIET_SWEEPS = 2,
  localparam int AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          abort,
  input  logic          w_valid,
  input  logic [3:0]    w_data,
  output logic          w_ready,
  input  logic          any_mod,
  output logic          neu_rst,
  output logic          neu_clr,
  output logic [AW-1:0] clr_addr,
  output logic          ld,
  output logic [AW-1:0] ld_addr,
  output logic [3:0]    ld_weight,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          blocked,
  output logic [7:0]    sweeps
);

  // Reset asserts immediately but releases only after two clean clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          blocked_q, blocked_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    sweeps_q, sweeps_d;
  logic [2:0]    phase_q, phase_d;
  logic [7:0]    quiet_q, quiet_d;

  logic          loader_clr;
  logic          accept;
  logic [AW-1:0] load_idx;
  logic          load_last;

  grid_seq_loader #(
    .CELLS (ROWS * COLS),
    .AW    (AW)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .clr       (loader_clr),
    .accept    (accept),
    .w_data    (w_data),
    .idx       (load_idx),
    .last      (load_last),
    .ld        (ld),
    .ld_addr   (ld_addr),
    .ld_weight (ld_weight)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    blocked_d  = blocked_q;
    timeout_d  = timeout_q;
    sweeps_d   = sweeps_q;
    phase_d    = 3'd0;
    quiet_d    = quiet_q;
    loader_clr = 1'b1;
    accept     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          addr_d    = start_addr;
          blocked_d = 1'b0;
          timeout_d = 1'b0;
          sweeps_d  = 8'd0;
          quiet_d   = 8'd0;
        end
      end
      ST_LOAD: begin
        // An aborted cycle must not produce a load strobe.
        loader_clr = abort;
        accept     = w_valid & ~abort;
        if (accept && load_idx == addr_q && w_data == WEIGHT_BLOCKED) blocked_d = 1'b1;
        if (abort)                  state_d = ST_IDLE;
        else if (accept && load_last) state_d = ST_INIT;
      end
      ST_INIT: begin
        if (abort)          state_d = ST_IDLE;
        else if (blocked_q) state_d = ST_DONE;
        else                state_d = ST_RUN;
      end
      ST_RUN: begin
        phase_d = phase_q + 3'd1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (phase_q == PHASE_LAST) begin
          sweeps_d = sat_inc8(sweeps_q);
          quiet_d  = any_mod ? 8'd0 : sat_inc8(quiet_q);
          // Convergence is tested first so it wins over a simultaneous limit.
          if (int'(quiet_d) >= QUIET_SWEEPS) begin
            state_d = ST_DONE;
          end else if (int'(sweeps_q) + 1 >= MAX_SWEEPS) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      blocked_q <= 1'b0;
      timeout_q <= 1'b0;
      sweeps_q  <= 8'd0;
      phase_q   <= 3'd0;
      quiet_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      blocked_q <= blocked_d;
      timeout_q <= timeout_d;
      sweeps_q  <= sweeps_d;
      phase_q   <= phase_d;
      quiet_q   <= quiet_d;
    end
  end

  assign w_ready  = (state_q == ST_LOAD);
  assign neu_rst  = (state_q == ST_INIT);
  assign neu_clr  = (state_q == ST_INIT) & ~blocked_q;
  assign clr_addr = neu_clr ? addr_q : '0;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign timeout  = timeout_q;
  assign blocked  = blocked_q;
  assign sweeps   = sweeps_q;

endmodule

// File: tb/tb_grid_seq.sv
// Bench for grid_seq: two 2x2 instances (sweep limits 255 and 4) share stimulus.
module tb_grid_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] start_addr = 2'd0;
  logic       abort = 1'b0;
  logic       w_valid = 1'b0;
  logic [3:0] w_data = 4'h0;
  logic       any_mod = 1'b0;

  logic       a_w_ready, a_neu_rst, a_neu_clr, a_ld, a_busy, a_done, a_timeout, a_blocked;
  logic [1:0] a_clr_addr, a_ld_addr;
  logic [3:0] a_ld_weight;
  logic [7:0] a_sweeps;
  logic       b_w_ready, b_neu_rst, b_neu_clr, b_ld, b_busy, b_done, b_timeout, b_blocked;
  logic [1:0] b_clr_addr, b_ld_addr;
  logic [3:0] b_ld_weight;
  logic [7:0] b_sweeps;

  always #5 clk = ~clk;

  grid_seq #(.ROWS(2), .COLS(2), .MAX_SWEEPS(255), .QUIET_SWEEPS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .abort(abort),
    .w_valid(w_valid), .w_data(w_data), .w_ready(a_w_ready), .any_mod(any_mod),
    .neu_rst(a_neu_rst), .neu_clr(a_neu_clr), .clr_addr(a_clr_addr), .ld(a_ld),
    .ld_addr(a_ld_addr), .ld_weight(a_ld_weight), .busy(a_busy), .done(a_done),
    .timeout(a_timeout), .blocked(a_blocked), .sweeps(a_sweeps));

  grid_seq #(.ROWS(2), .COLS(2), .MAX_SWEEPS(4), .QUIET_SWEEPS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .abort(abort),
    .w_valid(w_valid), .w_data(w_data), .w_ready(b_w_ready), .any_mod(any_mod),
    .neu_rst(b_neu_rst), .neu_clr(b_neu_clr), .clr_addr(b_clr_addr), .ld(b_ld),
    .ld_addr(b_ld_addr), .ld_weight(b_ld_weight), .busy(b_busy), .done(b_done),
    .timeout(b_timeout), .blocked(b_blocked), .sweeps(b_sweeps));

  // Observed instance selected per test.
  logic       sel = 1'b0;
  wire        o_w_ready   = sel ? b_w_ready   : a_w_ready;
  wire        o_neu_rst   = sel ? b_neu_rst   : a_neu_rst;
  wire        o_neu_clr   = sel ? b_neu_clr   : a_neu_clr;
  wire  [1:0] o_clr_addr  = sel ? b_clr_addr  : a_clr_addr;
  wire        o_ld        = sel ? b_ld        : a_ld;
  wire  [1:0] o_ld_addr   = sel ? b_ld_addr   : a_ld_addr;
  wire  [3:0] o_ld_weight = sel ? b_ld_weight : a_ld_weight;
  wire        o_busy      = sel ? b_busy      : a_busy;
  wire        o_done      = sel ? b_done      : a_done;
  wire        o_timeout   = sel ? b_timeout   : a_timeout;
  wire        o_blocked   = sel ? b_blocked   : a_blocked;
  wire  [7:0] o_sweeps    = sel ? b_sweeps    : a_sweeps;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: outcome of a solve from the sweep-by-sweep any_mod pattern.
  function automatic void model(input logic [15:0] wts, input int sa, input logic [31:0] pat,
                                input int mx, output int e_sw, output bit e_to, output bit e_blk);
    int q;
    logic m;
    e_blk = (wts[4*sa +: 4] == 4'hF);
    e_sw  = 0;
    e_to  = 1'b0;
    if (e_blk) return;
    q = 0;
    for (int s = 1; s <= mx; s++) begin
      m = (s <= 32) ? pat[s-1] : 1'b0;
      q = m ? 0 : q + 1;
      if (q >= 2) begin e_sw = s; return; end
      if (s == mx) begin e_sw = s; e_to = 1'b1; return; end
    end
  endfunction

  task automatic wait_idle(input string tag);
    int cyc = 0;
    any_mod = 1'b0;
    while ((a_busy || b_busy) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " idle wait"}, {31'd0, a_busy | b_busy}, 32'd0);
  endtask

  task automatic run_solve(input bit s, input logic [15:0] wts, input int sa, input logic [31:0] pat,
                           input int vpct, input int abort_sw, input int e_sw, input bit e_to,
                           input bit e_blk, input string tag);
    int  i, cyc, dn;
    bit  v, aborted;
    sel = s;
    start_addr = 2'(sa);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " load busy"}, {31'd0, o_busy}, 32'd1);
    chk({tag, " w_ready"}, {31'd0, o_w_ready}, 32'd1);
    i = 0; cyc = 0;
    while (i < 4 && cyc < 200) begin
      v = ($urandom_range(99) < vpct);
      w_valid = v;
      w_data  = wts[4*i +: 4];
      @(negedge clk);
      cyc++;
      chk($sformatf("%s ld beat%0d", tag, i), {31'd0, o_ld}, {31'd0, v});
      if (v) begin
        chk($sformatf("%s ld_addr%0d", tag, i), {30'd0, o_ld_addr}, i);
        chk($sformatf("%s ld_weight%0d", tag, i), {28'd0, o_ld_weight}, {28'd0, wts[4*i +: 4]});
        i++;
      end
    end
    w_valid = 1'b0;
    chk({tag, " beats loaded"}, i, 4);
    chk({tag, " init neu_rst"}, {31'd0, o_neu_rst}, 32'd1);
    chk({tag, " init neu_clr"}, {31'd0, o_neu_clr}, {31'd0, ~e_blk});
    if (!e_blk) chk({tag, " init clr_addr"}, {30'd0, o_clr_addr}, sa);
    chk({tag, " blocked"}, {31'd0, o_blocked}, {31'd0, e_blk});
    aborted = 1'b0;
    for (int sw = 1; sw <= e_sw && !aborted; sw++) begin
      for (int ph = 0; ph < 8 && !aborted; ph++) begin
        @(negedge clk);
        start = 1'b0;
        start_addr = 2'(sa);
        if (sw == 1 && ph == 0) chk({tag, " run neu_rst"}, {31'd0, o_neu_rst | o_neu_clr}, 32'd0);
        any_mod = (sw <= 32) ? pat[sw-1] : 1'b0;
        if (ph == 7) chk($sformatf("%s no done sweep%0d", tag, sw), {31'd0, o_done}, 32'd0);
        // A start while running must be ignored.
        if (sw == 1 && ph == 2) begin start = 1'b1; start_addr = 2'(sa + 1); end
        if (sw == abort_sw && ph == 3) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          aborted = 1'b1;
          chk({tag, " abort busy"}, {31'd0, o_busy}, 32'd0);
          dn = 0;
          for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_done) dn++;
          end
          chk({tag, " abort no done"}, dn, 0);
        end
      end
    end
    if (!aborted) begin
      @(negedge clk);
      chk({tag, " done"}, {31'd0, o_done}, 32'd1);
      chk({tag, " sweeps"}, {24'd0, o_sweeps}, e_sw);
      chk({tag, " timeout"}, {31'd0, o_timeout}, {31'd0, e_to});
      chk({tag, " done neu_clr"}, {31'd0, o_neu_clr}, 32'd0);
      @(negedge clk);
      chk({tag, " idle busy"}, {31'd0, o_busy | o_done}, 32'd0);
      chk({tag, " sticky sweeps"}, {24'd0, o_sweeps}, e_sw);
    end
    wait_idle(tag);
  endtask

  typedef struct {
    bit          sel;
    logic [15:0] wts;
    int          sa;
    logic [31:0] pat;
    int          vpct;
    int          e_sw;
    bit          e_to;
    bit          e_blk;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int e_sw;
    bit e_to, e_blk;
    logic [15:0] rw;
    int rsa;
    bit rsel;

    tbl[0] = '{1'b0, 16'h1111, 0, 32'h7, 100, 5, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'h1111, 0, 32'hFFFFFFFF, 100, 4, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 16'h1F11, 2, 32'h0, 100, 0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 16'h4321, 3, 32'h0, 50, 2, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 16'h2222, 1, 32'h5, 70, 5, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 16'h9876, 2, 32'h6, 70, 4, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 16'h1111, 3, 32'h3, 80, 4, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 16'h111F, 1, 32'h0, 60, 2, 1'b0, 1'b0};

    // Reset state.
    #3;
    chk("rst busy", {31'd0, a_busy | b_busy}, 32'd0);
    chk("rst outputs", {29'd0, a_ld, a_neu_rst, a_w_ready}, 32'd0);
    chk("rst status", {22'd0, a_timeout, a_blocked, a_sweeps}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post rst idle", {30'd0, a_busy, a_done}, 32'd0);

    foreach (tbl[n])
      run_solve(tbl[n].sel, tbl[n].wts, tbl[n].sa, tbl[n].pat, tbl[n].vpct, 0,
                tbl[n].e_sw, tbl[n].e_to, tbl[n].e_blk, $sformatf("tbl%0d", n));

    // Abort during sweep 2, then a normal solve.
    run_solve(1'b0, 16'h1111, 1, 32'hFFFFFFFF, 100, 2, 10, 1'b0, 1'b0, "abort_run");
    run_solve(1'b0, 16'h1111, 1, 32'h1, 100, 0, 3, 1'b0, 1'b0, "after_abort");

    // Abort in LOAD with a beat offered on the same cycle.
    sel = 1'b0;
    start_addr = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w_valid = 1'b1; w_data = 4'h3;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; w_valid = 1'b0;
    chk("load abort ld", {31'd0, a_ld}, 32'd0);
    chk("load abort busy", {31'd0, a_busy}, 32'd0);
    run_solve(1'b0, 16'h5555, 0, 32'h0, 100, 0, 2, 1'b0, 1'b0, "after_load_abort");

    // Randomised solves against the model.
    for (int r = 0; r < 6; r++) begin
      rsel = 1'($urandom_range(1));
      rsa  = $urandom_range(3);
      rw   = 16'($urandom);
      if ($urandom_range(3) == 0) rw[4*rsa +: 4] = 4'hF;
      begin
        logic [31:0] rp;
        rp = $urandom & 32'h000FFFFF;
        model(rw, rsa, rp, rsel ? 4 : 255, e_sw, e_to, e_blk);
        run_solve(rsel, rw, rsa, rp, 60, 0, e_sw, e_to, e_blk, $sformatf("rnd%0d", r));
      end
    end

    // Reset pulsed mid-LOAD with w_valid held high.
    sel = 1'b0;
    start_addr = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w_valid = 1'b1; w_data = 4'h7;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midload rst ld", {31'd0, a_ld | b_ld}, 32'd0);
    chk("midload rst busy", {30'd0, a_busy, a_w_ready}, 32'd0);
    chk("midload rst sweeps", {24'd0, a_sweeps}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      chk($sformatf("midload no ld %0d", k), {31'd0, a_ld | b_ld}, 32'd0);
    end
    w_valid = 1'b0;
    chk("midload idle", {31'd0, a_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
